// File: rtl/msi_pkg.sv
// Shared encodings for the MSI private cache controller:
// line coherence states, snooping-bus commands and controller FSM states.
package msi_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_S = 2'b01,
        ST_M = 2'b10
    } line_state_t;

    typedef enum logic [1:0] {
        CMD_BUSRD   = 2'd0,
        CMD_BUSRDX  = 2'd1,
        CMD_BUSUPGR = 2'd2,
        CMD_WB      = 2'd3
    } bus_cmd_t;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_WB,
        FSM_FILL,
        FSM_UPGR,
        FSM_DONE
    } fsm_state_t;

endpackage

// File: rtl/msi_line_array.sv
// Direct-mapped line storage {state, tag, data} with one local write port at the
// CPU index and one snoop state-update port; the snoop wins when both hit one line.
module msi_line_array
    import msi_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  cpu_idx,
    output line_state_t       cpu_state,
    output logic [TAG_W-1:0]  cpu_tag,
    output logic [DATA_W-1:0] cpu_data,
    input  logic [IDX_W-1:0]  snp_idx,
    output line_state_t       snp_state,
    output logic [TAG_W-1:0]  snp_tag,
    output logic [DATA_W-1:0] snp_data,
    input  logic              wr_en,
    input  line_state_t       wr_state,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              snp_upd,
    input  line_state_t       snp_new_state
);

    line_state_t       state_mem [LINES];
    logic [TAG_W-1:0]  tag_mem   [LINES];
    logic [DATA_W-1:0] data_mem  [LINES];
    logic              local_wr;

    assign local_wr = wr_en && !(snp_upd && (snp_idx == cpu_idx));

    // NOTE: non-blocking assignments for every piece of sequential state, so all
    // flops update together at the edge regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) state_mem[i] <= ST_I;
        end else begin
            if (local_wr) state_mem[cpu_idx] <= wr_state;
            if (snp_upd)  state_mem[snp_idx] <= snp_new_state;
        end
    end

    // NOTE: only the coherence state is reset; tag and data are meaningless while
    // the line is I, so they stay unreset and can map onto plain storage.
    always_ff @(posedge clk) begin
        if (local_wr) begin
            tag_mem[cpu_idx]  <= wr_tag;
            data_mem[cpu_idx] <= wr_data;
        end
    end

    assign cpu_state = state_mem[cpu_idx];
    assign cpu_tag   = tag_mem[cpu_idx];
    assign cpu_data  = data_mem[cpu_idx];
    assign snp_state = state_mem[snp_idx];
    assign snp_tag   = tag_mem[snp_idx];
    assign snp_data  = data_mem[snp_idx];

endmodule

// File: rtl/msi_cache_ctrl.sv
// Direct-mapped write-back MSI private cache controller: serves core loads/stores,
// drives BusRd/BusRdX/BusUpgr/WriteBack on the shared bus and answers snoops.
module msi_cache_ctrl
    import msi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              bus_req,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_grant,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              snp_valid,
    input  logic [1:0]        snp_cmd,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              snp_hit,
    output logic              snp_flush,
    output logic [DATA_W-1:0] snp_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int TAG_W = ADDR_W - IDX_W - OFF;

    logic [IDX_W-1:0]  cpu_idx, snp_idx;
    logic [TAG_W-1:0]  cpu_tag, snp_tag, line_tag, snp_line_tag, wr_tag;
    logic [DATA_W-1:0] line_data, snp_line_data, wr_data;
    line_state_t       line_state, snp_line_state, wr_state, snp_new_state;
    logic              wr_en, snp_upd, snp_match, snp_flush_n, conflict, line_hit;
    logic              unused_addr_bits;

    fsm_state_t        fsm_q, fsm_n;
    bus_cmd_t          bus_cmd_q, bus_cmd_n;
    logic              bus_req_q, bus_req_n, hit_q, hit_n, ack_pend_q, ack_pend_n;
    logic              granted_q, granted_n, cpu_ready_q, cpu_ready_n, cpu_hit_q, cpu_hit_n;
    logic              snp_hit_q, snp_flush_q;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_n;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_n, fill_q, fill_n;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_n, snp_data_q;

    assign cpu_idx = cpu_addr[OFF +: IDX_W];
    assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign snp_idx = snp_addr[OFF +: IDX_W];
    assign snp_tag = snp_addr[ADDR_W-1 -: TAG_W];
    assign unused_addr_bits = ^{cpu_addr[OFF-1:0], snp_addr[OFF-1:0]};

    msi_line_array #(.LINES(LINES), .TAG_W(TAG_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_lines (
        .clk(clk), .reset(reset),
        .cpu_idx(cpu_idx), .cpu_state(line_state), .cpu_tag(line_tag), .cpu_data(line_data),
        .snp_idx(snp_idx), .snp_state(snp_line_state), .snp_tag(snp_line_tag), .snp_data(snp_line_data),
        .wr_en(wr_en), .wr_state(wr_state), .wr_tag(wr_tag), .wr_data(wr_data),
        .snp_upd(snp_upd), .snp_new_state(snp_new_state)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        snp_upd       = 1'b0;
        snp_new_state = ST_I;
        snp_flush_n   = 1'b0;
        snp_match     = snp_valid && (snp_line_state != ST_I) && (snp_line_tag == snp_tag);
        if (snp_match) begin
            case (bus_cmd_t'(snp_cmd))
                CMD_BUSRD: if (snp_line_state == ST_M) begin
                    snp_upd = 1'b1; snp_new_state = ST_S; snp_flush_n = 1'b1;
                end
                CMD_BUSRDX: begin
                    snp_upd     = 1'b1;
                    snp_flush_n = (snp_line_state == ST_M);
                end
                CMD_BUSUPGR: snp_upd = (snp_line_state == ST_S);
                default: ;
            endcase
        end
    end

    // Local writes always target the CPU index (the victim shares it), so a snoop
    // update there blocks this cycle's local write and the FSM retries.
    assign conflict = snp_upd && (snp_idx == cpu_idx);
    assign line_hit = (line_state != ST_I) && (line_tag == cpu_tag);

    always_comb begin
        fsm_n       = fsm_q;
        bus_req_n   = bus_req_q;
        bus_cmd_n   = bus_cmd_q;
        bus_addr_n  = bus_addr_q;
        bus_wdata_n = bus_wdata_q;
        hit_n       = hit_q;
        ack_pend_n  = ack_pend_q;
        granted_n   = granted_q;
        fill_n      = fill_q;
        cpu_ready_n = 1'b0;
        cpu_hit_n   = 1'b0;
        cpu_rdata_n = cpu_rdata_q;
        wr_en       = 1'b0;
        wr_state    = ST_I;
        wr_tag      = cpu_tag;
        wr_data     = cpu_wdata;

        if (bus_req_q && bus_grant) granted_n = 1'b1;
        if (bus_req_q && bus_ack) begin
            bus_req_n = 1'b0;
            granted_n = 1'b0;
            fill_n    = bus_rdata;
        end

        case (fsm_q)
            FSM_IDLE: begin
                // cpu_ready_q masks the still-held request of the access just completed.
                if (cpu_req && !cpu_ready_q && !(snp_valid && (snp_idx == cpu_idx))) begin
                    hit_n      = 1'b0;
                    granted_n  = 1'b0;
                    bus_addr_n = {cpu_tag, cpu_idx, {OFF{1'b0}}};
                    if (line_hit && (!cpu_rw || line_state == ST_M)) begin
                        hit_n    = 1'b1;
                        wr_en    = cpu_rw;
                        wr_state = ST_M;
                        fsm_n    = FSM_DONE;
                    end else if (line_hit) begin
                        bus_req_n = 1'b1;
                        bus_cmd_n = CMD_BUSUPGR;
                        fsm_n     = FSM_UPGR;
                    end else if (line_state == ST_M) begin
                        bus_req_n   = 1'b1;
                        bus_cmd_n   = CMD_WB;
                        bus_addr_n  = {line_tag, cpu_idx, {OFF{1'b0}}};
                        bus_wdata_n = line_data;
                        fsm_n       = FSM_WB;
                    end else begin
                        bus_req_n = 1'b1;
                        bus_cmd_n = cpu_rw ? CMD_BUSRDX : CMD_BUSRD;
                        fsm_n     = FSM_FILL;
                    end
                end
            end
            FSM_WB: begin
                if (bus_ack || ack_pend_q) begin
                    ack_pend_n = conflict;
                    if (!conflict) begin
                        wr_en    = 1'b1;
                        wr_state = ST_I;
                        wr_tag   = line_tag;
                        wr_data  = line_data;
                        fsm_n    = FSM_FILL;
                    end
                end
            end
            FSM_FILL: begin
                if (bus_ack || ack_pend_q) begin
                    ack_pend_n = conflict;
                    if (!conflict) begin
                        wr_en    = 1'b1;
                        wr_state = cpu_rw ? ST_M : ST_S;
                        wr_data  = cpu_rw ? cpu_wdata : (ack_pend_q ? fill_q : bus_rdata);
                        fsm_n    = FSM_DONE;
                    end
                end else if (!bus_req_q) begin
                    bus_req_n  = 1'b1;
                    bus_cmd_n  = cpu_rw ? CMD_BUSRDX : CMD_BUSRD;
                    bus_addr_n = {cpu_tag, cpu_idx, {OFF{1'b0}}};
                end
            end
            FSM_UPGR: begin
                if (bus_ack || ack_pend_q) begin
                    ack_pend_n = conflict;
                    if (!conflict) begin
                        wr_en    = 1'b1;
                        wr_state = ST_M;
                        fsm_n    = FSM_DONE;
                    end
                end else if (!granted_q && !bus_grant && conflict && snp_new_state == ST_I) begin
                    bus_cmd_n = CMD_BUSRDX;
                    fsm_n     = FSM_FILL;
                end
            end
            FSM_DONE: begin
                cpu_ready_n = 1'b1;
                cpu_hit_n   = hit_q;
                cpu_rdata_n = line_data;
                fsm_n       = FSM_IDLE;
            end
            default: fsm_n = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= FSM_IDLE;
            bus_req_q   <= 1'b0;
            bus_cmd_q   <= CMD_BUSRD;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            hit_q       <= 1'b0;
            ack_pend_q  <= 1'b0;
            granted_q   <= 1'b0;
            fill_q      <= '0;
            cpu_ready_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            cpu_rdata_q <= '0;
            snp_hit_q   <= 1'b0;
            snp_flush_q <= 1'b0;
            snp_data_q  <= '0;
        end else begin
            fsm_q       <= fsm_n;
            bus_req_q   <= bus_req_n;
            bus_cmd_q   <= bus_cmd_n;
            bus_addr_q  <= bus_addr_n;
            bus_wdata_q <= bus_wdata_n;
            hit_q       <= hit_n;
            ack_pend_q  <= ack_pend_n;
            granted_q   <= granted_n;
            fill_q      <= fill_n;
            cpu_ready_q <= cpu_ready_n;
            cpu_hit_q   <= cpu_hit_n;
            cpu_rdata_q <= cpu_rdata_n;
            snp_hit_q   <= snp_match;
            snp_flush_q <= snp_flush_n;
            snp_data_q  <= snp_flush_n ? snp_line_data : '0;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_hit   = cpu_hit_q;
    assign cpu_rdata = cpu_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_cmd   = bus_cmd_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign snp_hit   = snp_hit_q;
    assign snp_flush = snp_flush_q;
    assign snp_data  = snp_data_q;

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed bench for msi_cache_ctrl: miss/hit, upgrade, dirty eviction, snoops,
// upgrade-to-RdX switch and mid-transaction reset, with hand-computed expectations.
module tb_msi_cache_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINES  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_rw, cpu_ready, cpu_hit;
    logic [ADDR_W-1:0] cpu_addr, bus_addr, snp_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata, bus_wdata, bus_rdata, snp_data;
    logic              bus_req, bus_grant, bus_ack, snp_valid, snp_hit, snp_flush;
    logic [1:0]        bus_cmd, snp_cmd;

    int n_cmp  = 0;
    int n_fail = 0;

    msi_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_grant(bus_grant), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
        .snp_hit(snp_hit), .snp_flush(snp_flush), .snp_data(snp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cpu_start(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic cpu_finish(input string tag, input logic exp_hit, input logic chk_rdata,
                              input logic [31:0] exp_rdata, input int exp_lat);
        int n = 0;
        do begin tick(); n++; end while (!cpu_ready && n < 100);
        check({tag, "_ready"}, cpu_ready, 1'b1);
        check({tag, "_hit"}, cpu_hit, exp_hit);
        if (chk_rdata) check({tag, "_rdata"}, cpu_rdata, exp_rdata);
        if (exp_lat != 0) check({tag, "_latency"}, n, exp_lat);
        cpu_req = 1'b0;
    endtask

    task automatic wait_bus_req(input string tag);
        int n = 0;
        while (!bus_req && n < 50) begin tick(); n++; end
        check({tag, "_req_seen"}, bus_req, 1'b1);
    endtask

    task automatic bus_serve(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                             input logic chk_wdata, input logic [31:0] wdata, input logic [31:0] rdata);
        wait_bus_req(tag);
        check({tag, "_cmd"}, bus_cmd, cmd);
        check({tag, "_addr"}, bus_addr, addr);
        if (chk_wdata) check({tag, "_wdata"}, bus_wdata, wdata);
        bus_grant = 1'b1; tick(); bus_grant = 1'b0; tick();
        check({tag, "_cmd_stable"}, bus_cmd, cmd);
        bus_ack = 1'b1; bus_rdata = rdata; tick();
        bus_ack = 1'b0; bus_rdata = '0;
    endtask

    task automatic snoop(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                         input logic exp_hit, input logic exp_flush, input logic [31:0] exp_data);
        snp_valid = 1'b1; snp_cmd = cmd; snp_addr = addr;
        tick();
        snp_valid = 1'b0;
        check({tag, "_snp_hit"}, snp_hit, exp_hit);
        check({tag, "_snp_flush"}, snp_flush, exp_flush);
        if (exp_flush) check({tag, "_snp_data"}, snp_data, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus_grant = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        snp_valid = 1'b0; snp_cmd = '0; snp_addr = '0;
        tick(); tick();
        check("rst_cpu_ready", cpu_ready, 1'b0);
        check("rst_cpu_hit", cpu_hit, 1'b0);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_snp", {snp_hit, snp_flush}, 2'b00);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_cmd_wdata", {bus_cmd, bus_wdata}, 34'h0);
        check("rst_snp_data", snp_data, 32'h0);
        reset = 1'b0;
        tick();

        // Read miss 0x100 (idx 0, tag 4): BusRd fill, line -> S.
        cpu_start(1'b0, 32'h100, 32'h0);
        bus_serve("rd_miss", 2'd0, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF);
        cpu_finish("rd_miss", 1'b0, 1'b1, 32'hDEADBEEF, 0);
        tick();
        cpu_start(1'b0, 32'h100, 32'h0);
        cpu_finish("rd_hit", 1'b1, 1'b1, 32'hDEADBEEF, 2);
        tick();
        check("ready_one_cycle", cpu_ready, 1'b0);
        snoop("snp_rd_on_s", 2'd0, 32'h100, 1'b1, 1'b0, 32'h0);

        // Write hit on S: BusUpgr, line -> M with 0x5; snoop BusRd flushes and demotes.
        cpu_start(1'b1, 32'h100, 32'h5);
        bus_serve("upgr", 2'd2, 32'h100, 1'b0, 32'h0, 32'h0);
        cpu_finish("upgr", 1'b0, 1'b0, 32'h0, 0);
        snoop("snp_rd_on_m", 2'd0, 32'h100, 1'b1, 1'b1, 32'h5);
        tick();
        check("snp_one_cycle", {snp_hit, snp_flush}, 2'b00);
        snoop("snp_rd_after_flush", 2'd0, 32'h100, 1'b1, 1'b0, 32'h0);

        // Back to M, then a write hit on M completes locally.
        cpu_start(1'b1, 32'h100, 32'h77);
        bus_serve("upgr2", 2'd2, 32'h100, 1'b0, 32'h0, 32'h0);
        cpu_finish("upgr2", 1'b0, 1'b0, 32'h0, 0);
        tick();
        cpu_start(1'b1, 32'h100, 32'h99);
        cpu_finish("wr_hit_m", 1'b1, 1'b0, 32'h0, 2);
        tick();

        // Write 0x140 (same index, tag 5): dirty victim written back, then BusRdX.
        cpu_start(1'b1, 32'h140, 32'hAB);
        bus_serve("evict_wb", 2'd3, 32'h100, 1'b1, 32'h99, 32'h0);
        check("wb_req_drop", bus_req, 1'b0);
        bus_serve("evict_rdx", 2'd1, 32'h140, 1'b0, 32'h0, 32'h1111);
        cpu_finish("evict", 1'b0, 1'b0, 32'h0, 0);

        // Tag mismatch and I-line snoops leave everything alone.
        snoop("snp_tag_miss", 2'd1, 32'h100, 1'b0, 1'b0, 32'h0);
        tick();
        cpu_start(1'b0, 32'h140, 32'h0);
        cpu_finish("rd_after_miss_snp", 1'b1, 1'b1, 32'hAB, 2);
        snoop("snp_i_line", 2'd0, 32'h104, 1'b0, 1'b0, 32'h0);
        snoop("snp_rdx_on_m", 2'd1, 32'h140, 1'b1, 1'b1, 32'hAB);
        snoop("snp_after_inval", 2'd0, 32'h140, 1'b0, 1'b0, 32'h0);

        // Upgrade of 0x200 overtaken by a snooped BusRdX before grant.
        cpu_start(1'b0, 32'h200, 32'h0);
        bus_serve("rd_200", 2'd0, 32'h200, 1'b0, 32'h0, 32'h2222);
        cpu_finish("rd_200", 1'b0, 1'b1, 32'h2222, 0);
        tick();
        cpu_start(1'b1, 32'h200, 32'hC0DE);
        wait_bus_req("upgr_race");
        check("upgr_race_cmd0", bus_cmd, 2'd2);
        snoop("upgr_race", 2'd1, 32'h200, 1'b1, 1'b0, 32'h0);
        check("upgr_race_cmd_rdx", bus_cmd, 2'd1);
        check("upgr_race_req_held", bus_req, 1'b1);
        bus_grant = 1'b1; tick(); bus_grant = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h3333; tick();
        bus_ack = 1'b0; bus_rdata = '0;
        cpu_finish("upgr_race", 1'b0, 1'b0, 32'h0, 0);
        snoop("upgr_race_line_m", 2'd0, 32'h200, 1'b1, 1'b1, 32'hC0DE);

        // Reset during a FILL: bus_req drops asynchronously and every line is I.
        tick();
        cpu_start(1'b0, 32'h300, 32'h0);
        wait_bus_req("rst_fill");
        check("rst_fill_cmd", bus_cmd, 2'd0);
        #1 reset = 1'b1;
        #1 check("rst_async_bus_req", bus_req, 1'b0);
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        snoop("rst_line_i", 2'd0, 32'h200, 1'b0, 1'b0, 32'h0);
        cpu_start(1'b0, 32'h200, 32'h0);
        bus_serve("rst_rd_miss", 2'd0, 32'h200, 1'b0, 32'h0, 32'h4444);
        cpu_finish("rst_rd_miss", 1'b0, 1'b1, 32'h4444, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
